// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: detector codes and pipeline status in, stall/flush/forward controls out.
// The hazard detectors and pipeline side use the master modport; the controller uses the slave modport.
interface hazard_ctrl_if #(
  parameter int STAT_W = 16
);
  logic [5:0]        hz1;
  logic [5:0]        hz2;
  logic              br_taken_e;
  logic              mem_busy;
  logic              stall_f;
  logic              stall_d;
  logic              stall_e;
  logic              flush_d;
  logic              flush_e;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              mem_err;
  logic [STAT_W-1:0] stall_cnt;
  logic [STAT_W-1:0] flush_cnt;

  modport master (
    output hz1, hz2, br_taken_e, mem_busy,
    input  stall_f, stall_d, stall_e, flush_d, flush_e,
    input  fwd_a, fwd_b, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  hz1, hz2, br_taken_e, mem_busy,
    output stall_f, stall_d, stall_e, flush_d, flush_e,
    output fwd_a, fwd_b, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/bubble/flush sequencing, registered EX forward selects, memory timeout.
// Optional statistics counters are built only when HAZ_STATS_EN is defined.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int STAT_W      = 16
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave io_hz
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LD_STALL = 2'd1,
    ST_BR_FLUSH = 2'd2,
    ST_MEM_WAIT = 2'd3
  } state_t;

  localparam int              TO_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT);

  state_t          r_state;
  state_t          w_state_next;
  logic            w_stall_f;
  logic            w_stall_d;
  logic            w_stall_e;
  logic            w_flush_d;
  logic            w_flush_e;
  logic            w_load_use;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_mem_err;
  logic            w_unused;

  assign w_load_use = (io_hz.hz1 == 6'b111111);
  assign w_unused   = &{1'b0, io_hz.hz2[5:4]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Once mem_busy has dropped, MEM_WAIT resolves hazards exactly like RUN so a
  // branch that was frozen in EX is flushed in the cycle the pipeline advances.
  always_comb begin
    w_state_next = r_state;
    w_stall_f    = 1'b0;
    w_stall_d    = 1'b0;
    w_stall_e    = 1'b0;
    w_flush_d    = 1'b0;
    w_flush_e    = 1'b0;
    if (rst) begin
      w_state_next = ST_RUN;
    end else if (io_hz.mem_busy) begin
      w_stall_f    = 1'b1;
      w_stall_d    = 1'b1;
      w_stall_e    = 1'b1;
      w_state_next = ST_MEM_WAIT;
    end else begin
      case (r_state)
        ST_RUN, ST_MEM_WAIT: begin
          if (io_hz.br_taken_e) begin
            w_flush_d    = 1'b1;
            w_flush_e    = 1'b1;
            w_state_next = ST_BR_FLUSH;
          end else if (w_load_use) begin
            w_stall_f    = 1'b1;
            w_stall_d    = 1'b1;
            w_flush_e    = 1'b1;
            w_state_next = ST_LD_STALL;
          end else begin
            w_state_next = ST_RUN;
          end
        end
        default: w_state_next = ST_RUN;
      endcase
    end
  end

  assign io_hz.stall_f = w_stall_f;
  assign io_hz.stall_d = w_stall_d;
  assign io_hz.stall_e = w_stall_e;
  assign io_hz.flush_d = w_flush_d;
  assign io_hz.flush_e = w_flush_e;

  // Operand A lives in code bits [3:2] (gi=0), operand B in [1:0] (gi=1).
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi = gi + 1) begin : g_fwd
      logic [1:0] w_code1;
      logic [1:0] w_code2;
      logic [1:0] w_dec;
      logic [1:0] r_sel;

      assign w_code1 = io_hz.hz1[3-2*gi -: 2];
      assign w_code2 = io_hz.hz2[3-2*gi -: 2];
      assign w_dec   = (w_code1 == 2'b01) ? 2'b01 :
                       (w_code2 == 2'b01) ? 2'b10 : 2'b00;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_sel <= 2'b00;
        end else if (w_flush_e) begin
          r_sel <= 2'b00;
        end else if (!w_stall_e) begin
          r_sel <= w_dec;
        end
      end
    end
  endgenerate

  assign io_hz.fwd_a = g_fwd[0].r_sel;
  assign io_hz.fwd_b = g_fwd[1].r_sel;

  // Counts consecutive frozen cycles; the error latches on the cycle the count reaches the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt  <= '0;
      r_mem_err <= 1'b0;
    end else if (io_hz.mem_busy) begin
      if (r_to_cnt != TO_MAX) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (r_to_cnt >= TO_MAX - 1'b1) begin
        r_mem_err <= 1'b1;
      end
    end else begin
      r_to_cnt <= '0;
    end
  end

  assign io_hz.mem_err = r_mem_err;

`ifdef HAZ_STATS_EN
  logic [STAT_W-1:0] r_stall_cnt;
  logic [STAT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!io_hz.mem_busy) begin
      if (w_state_next == ST_LD_STALL) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_state_next == ST_BR_FLUSH) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign io_hz.stall_cnt = r_stall_cnt;
  assign io_hz.flush_cnt = r_flush_cnt;
`else
  assign io_hz.stall_cnt = '0;
  assign io_hz.flush_cnt = '0;
`endif

endmodule
